epl_integrate_dump: RTL and testbench
=====================================

Name: epl_integrate_dump

Overview:
Parametrised early/prompt/late carrier-wipe-off correlator with integrate-and-dump, for the GPS tracking channel. Mixes each input sample with a local I/Q carrier and with NUM_TAPS time-shifted copies of the local PRN chip, then accumulates over one code epoch. At each epoch it dumps per-tap I/Q sums to a valid/ready output for the Costas and DLL discriminators. Generalises the single punctual I/Q multiply to N taps with programmable spacing, integration and backpressure.

Parameters:
IN_W, 3, signed sample width
LO_W, 4, signed local-oscillator (sin/cos) width
ACC_W, 32, signed accumulator width; must be >= IN_W+LO_W+1
NUM_TAPS, 3, number of code taps, odd, >= 1; middle tap is prompt
SPACING, 1, samples between adjacent taps, >= 1
CNT_W, 16, sample-count width

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
sample_valid  in  1  sample/lo/prn/epoch qualifier
sample_in  in  IN_W  signed IF sample
lo_i  in  LO_W  signed local cosine
lo_q  in  LO_W  signed local sine
prn_chip  in  1  local code chip, 1 = +1, 0 = -1
epoch  in  1  this sample is first of a new integration period
out_valid  out  1  dump result available
out_ready  in  1  consumer accepts result
out_i  out  NUM_TAPS*ACC_W  per-tap I sums, tap 0 (earliest) in LSBs
out_q  out  NUM_TAPS*ACC_W  per-tap Q sums
out_count  out  CNT_W  samples in dumped period, saturating
overrun  out  1  sticky: a dump overwrote an unaccepted result

Behaviour:
- Reset (synchronous): all outputs 0, accumulators 0, count 0, delay line 0, pipeline valid 0, state IDLE.
- Code delay line: (NUM_TAPS-1)*SPACING flops, shifts on sample_valid. Tap k chip = prn_chip when k=0, otherwise delay element k*SPACING (k*SPACING samples old).
- Stage 1 (registered on sample_valid): pi = sample_in*lo_i, pq = sample_in*lo_q, computed in IN_W+LO_W+1 bits; per tap, negate when tap chip is 0. epoch and valid pipelined alongside.
- Stage 2 (accumulate): products sign-extended to ACC_W.
- FSM IDLE: stage-2 valid without epoch is ignored. Valid with epoch loads accumulators with current products, count=1, goes to INTEGRATE, no dump.
- FSM INTEGRATE: valid without epoch adds products, count+1, saturating at 2^CNT_W-1. Valid with epoch dumps: old accumulators and count go to the output registers and out_valid=1. Accumulators then load current products, count=1.
- Latency: epoch sample presented in cycle 0 gives out_valid high in cycle 2.
- Handshake: outputs stable while out_valid && !out_ready. out_valid clears on the cycle after out_valid && out_ready, unless a dump happens in that same cycle.
- Dump in the same cycle as out_ready: handshake completes, new data loads, out_valid stays 1, no overrun.
- Dump while out_valid && !out_ready: output registers are overwritten with the new data, overrun=1. overrun is sticky until RST.
- Accumulator overflow without the feature: two's-complement wrap.
- RST mid-period: the partial period is discarded, in-flight pipeline data is dropped, and the next epoch only arms (no dump).

Optional Feature:
Macro EPL_ACC_SAT_EN. When defined, every accumulator add saturates to the signed ACC_W limits [-2^(ACC_W-1), 2^(ACC_W-1)-1]. When undefined, accumulator adds wrap modulo 2^ACC_W. Count saturation is always present.

Decomposition:
- Package gps_corr_pkg: state enum (IDLE, INTEGRATE), default width constants, a sat_add function used under EPL_ACC_SAT_EN.
- Sub-module corr_tap_accum: one tap's I/Q accumulator pair with load/add/dump control. Instantiated NUM_TAPS times by a generate loop.
- Top level holds the delay line, stage 1, FSM, count and output handshake.

Test Plan:
- Defaults; prn=1 held for 4 samples, then epoch, 10 samples of sample_in=+3, lo_i=+1, lo_q=0, then epoch -> out_i = 30,30,30; out_q = 0,0,0; out_count=10; out_valid in cycle 2 after the second epoch.
- RST, then a single epoch with no prior epoch -> no out_valid; the next epoch 5 samples later -> out_count=5.
- prn repeating 1,1,0,0; sample_in = previous prn as ±1; lo_i=+1; epoch every 8 samples after warm-up -> out_i = 0,8,0 (early, prompt, late).
- out_ready=0 across two dumps of 10 and 12 samples -> overrun=1, out_count=12; then out_ready=1 -> out_valid drops the next cycle.
- ACC_W=8, sample_in=+3, lo_i=+7, 10 samples -> out_i=127 with EPL_ACC_SAT_EN, -46 without.
- RST pulsed mid-period -> all outputs 0 the next cycle; the following epoch produces no dump.

Source files
------------

// File: rtl/epl_integrate_dump_pkg.sv
// Shared definitions for the early/prompt/late integrate-and-dump correlator:
// the correlator state encoding, default widths and the saturating adder used
// when the design is built with EPL_ACC_SAT_EN.
package gps_corr_pkg;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    INTEGRATE = 1'b1
  } corr_state_e;

  localparam int DEF_IN_W     = 3;
  localparam int DEF_LO_W     = 4;
  localparam int DEF_ACC_W    = 32;
  localparam int DEF_NUM_TAPS = 3;
  localparam int DEF_SPACING  = 1;
  localparam int DEF_CNT_W    = 16;

  // Signed add clamped to the w-bit two's-complement range. Operands must
  // already lie inside that range (w <= 63), so the 64-bit sum cannot wrap.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int                 w);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi) begin
      return hi;
    end else if (s < lo) begin
      return lo;
    end else begin
      return s;
    end
  endfunction

endpackage

// File: rtl/epl_integrate_dump_if.sv
// Sample input and dump-result handshake bundle of the correlator. The
// master side drives samples and out_ready; the slave side is the correlator.
interface epl_integrate_dump_if #(
  parameter int IN_W     = 3,
  parameter int LO_W     = 4,
  parameter int ACC_W    = 32,
  parameter int NUM_TAPS = 3,
  parameter int CNT_W    = 16
);
  logic                         sample_valid;
  logic signed [IN_W-1:0]       sample_in;
  logic signed [LO_W-1:0]       lo_i;
  logic signed [LO_W-1:0]       lo_q;
  logic                         prn_chip;
  logic                         epoch;
  logic                         out_valid;
  logic                         out_ready;
  logic [NUM_TAPS*ACC_W-1:0]    out_i;
  logic [NUM_TAPS*ACC_W-1:0]    out_q;
  logic [CNT_W-1:0]             out_count;
  logic                         overrun;

  modport master (
    output sample_valid, sample_in, lo_i, lo_q, prn_chip, epoch, out_ready,
    input  out_valid, out_i, out_q, out_count, overrun
  );

  modport slave (
    input  sample_valid, sample_in, lo_i, lo_q, prn_chip, epoch, out_ready,
    output out_valid, out_i, out_q, out_count, overrun
  );
endinterface

// File: rtl/epl_integrate_dump_tap.sv
// One code tap's I/Q accumulator pair (module corr_tap_accum). i_load starts
// a new period with the current products, i_add accumulates them. Adds wrap
// modulo 2^ACC_W unless built with EPL_ACC_SAT_EN, which clamps them.
module corr_tap_accum
  import gps_corr_pkg::*;
#(
  parameter int PW    = 8,
  parameter int ACC_W = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    i_load,
  input  logic                    i_add,
  input  logic signed [PW-1:0]    i_prod_i,
  input  logic signed [PW-1:0]    i_prod_q,
  output logic signed [ACC_W-1:0] o_acc_i,
  output logic signed [ACC_W-1:0] o_acc_q
);

  logic signed [ACC_W-1:0] r_acc_i;
  logic signed [ACC_W-1:0] r_acc_q;
  logic signed [ACC_W-1:0] w_ext_i;
  logic signed [ACC_W-1:0] w_ext_q;
  logic signed [ACC_W-1:0] w_sum_i;
  logic signed [ACC_W-1:0] w_sum_q;

  assign w_ext_i = ACC_W'(i_prod_i);
  assign w_ext_q = ACC_W'(i_prod_q);

`ifdef EPL_ACC_SAT_EN
  assign w_sum_i = ACC_W'(sat_add(64'(r_acc_i), 64'(w_ext_i), ACC_W));
  assign w_sum_q = ACC_W'(sat_add(64'(r_acc_q), 64'(w_ext_q), ACC_W));
`else
  assign w_sum_i = r_acc_i + w_ext_i;
  assign w_sum_q = r_acc_q + w_ext_q;
`endif

  // Load on a period start, accumulate otherwise, hold when no sample arrives.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_acc_i <= '0;
      r_acc_q <= '0;
    end else if (i_load) begin
      r_acc_i <= w_ext_i;
      r_acc_q <= w_ext_q;
    end else if (i_add) begin
      r_acc_i <= w_sum_i;
      r_acc_q <= w_sum_q;
    end
  end

  assign o_acc_i = r_acc_i;
  assign o_acc_q = r_acc_q;

endmodule

// File: rtl/epl_integrate_dump.sv
// Early/prompt/late carrier-wipe-off correlator with integrate-and-dump.
// Holds the code delay line, the product stage, the IDLE/INTEGRATE control,
// the sample counter and the dump output handshake. Accumulator saturation is
// enabled by defining EPL_ACC_SAT_EN (wrap-around otherwise).
module epl_integrate_dump
  import gps_corr_pkg::*;
#(
  parameter int IN_W     = DEF_IN_W,
  parameter int LO_W     = DEF_LO_W,
  parameter int ACC_W    = DEF_ACC_W,
  parameter int NUM_TAPS = DEF_NUM_TAPS,
  parameter int SPACING  = DEF_SPACING,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                CLK,
  input  logic                RST,
  epl_integrate_dump_if.slave bus
);

  localparam int PW    = IN_W + LO_W + 1;
  localparam int DLY_N = (NUM_TAPS - 1) * SPACING;
  localparam int DLY_W = (DLY_N > 0) ? DLY_N : 1;

  localparam logic [0:0]       ST_IDLE      = IDLE;
  localparam logic [0:0]       ST_INTEGRATE = INTEGRATE;
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  logic [DLY_W-1:0]        r_dly;
  logic [NUM_TAPS-1:0]     w_chip;
  logic signed [PW-1:0]    w_pi;
  logic signed [PW-1:0]    w_pq;
  logic signed [PW-1:0]    r_pi [NUM_TAPS];
  logic signed [PW-1:0]    r_pq [NUM_TAPS];
  logic                    r_s1_valid;
  logic                    r_s1_epoch;
  logic [0:0]              r_state;
  logic [CNT_W-1:0]        r_count;
  logic                    w_load;
  logic                    w_add;
  logic                    w_dump;
  logic signed [ACC_W-1:0] w_acc_i [NUM_TAPS];
  logic signed [ACC_W-1:0] w_acc_q [NUM_TAPS];
  logic                    r_out_valid;
  logic [NUM_TAPS*ACC_W-1:0] r_out_i;
  logic [NUM_TAPS*ACC_W-1:0] r_out_q;
  logic [CNT_W-1:0]        r_out_count;
  logic                    r_overrun;

  // Code delay line: element j (r_dly[j-1]) holds the chip from j samples ago.
  generate
    if (DLY_W > 1) begin : g_dly_multi
      always_ff @(posedge CLK) begin
        if (RST) begin
          r_dly <= '0;
        end else if (bus.sample_valid) begin
          r_dly <= {r_dly[DLY_W-2:0], bus.prn_chip};
        end
      end
    end else begin : g_dly_single
      always_ff @(posedge CLK) begin
        if (RST) begin
          r_dly <= '0;
        end else if (bus.sample_valid) begin
          r_dly <= bus.prn_chip;
        end
      end
    end
  endgenerate

  // Tap 0 is the newest (early) chip; tap k lags it by k*SPACING samples.
  always_comb begin
    w_chip    = '0;
    w_chip[0] = bus.prn_chip;
    for (int k = 1; k < NUM_TAPS; k++) begin
      w_chip[k] = r_dly[k*SPACING-1];
    end
  end

  // Carrier wipe-off; the product fits comfortably in PW bits.
  assign w_pi = PW'(bus.sample_in) * PW'(bus.lo_i);
  assign w_pq = PW'(bus.sample_in) * PW'(bus.lo_q);

  // Product stage: per-tap code wipe-off, with valid/epoch carried alongside.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s1_valid <= 1'b0;
      r_s1_epoch <= 1'b0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        r_pi[k] <= '0;
        r_pq[k] <= '0;
      end
    end else begin
      r_s1_valid <= bus.sample_valid;
      r_s1_epoch <= bus.sample_valid & bus.epoch;
      if (bus.sample_valid) begin
        for (int k = 0; k < NUM_TAPS; k++) begin
          r_pi[k] <= w_chip[k] ? w_pi : -w_pi;
          r_pq[k] <= w_chip[k] ? w_pq : -w_pq;
        end
      end
    end
  end

  // An epoch always restarts the period; only an armed period gets dumped.
  assign w_load = r_s1_valid & r_s1_epoch;
  assign w_add  = r_s1_valid & ~r_s1_epoch & (r_state == ST_INTEGRATE);
  assign w_dump = w_load & (r_state == ST_INTEGRATE);

  generate
    for (genvar g = 0; g < NUM_TAPS; g++) begin : g_tap
      corr_tap_accum #(
        .PW    (PW),
        .ACC_W (ACC_W)
      ) u_acc (
        .CLK      (CLK),
        .RST      (RST),
        .i_load   (w_load),
        .i_add    (w_add),
        .i_prod_i (r_pi[g]),
        .i_prod_q (r_pq[g]),
        .o_acc_i  (w_acc_i[g]),
        .o_acc_q  (w_acc_q[g])
      );
    end
  endgenerate

  // Period control and saturating sample count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else if (w_load) begin
      r_state <= ST_INTEGRATE;
      r_count <= CNT_ONE;
    end else if (w_add) begin
      if (r_count != CNT_MAX) begin
        r_count <= r_count + CNT_ONE;
      end
    end
  end

  // Dump register and handshake: a dump wins over a completing handshake,
  // and a dump onto an unaccepted result sets the sticky overrun flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_out_valid <= 1'b0;
      r_out_i     <= '0;
      r_out_q     <= '0;
      r_out_count <= '0;
      r_overrun   <= 1'b0;
    end else if (w_dump) begin
      r_out_valid <= 1'b1;
      r_out_count <= r_count;
      for (int k = 0; k < NUM_TAPS; k++) begin
        r_out_i[k*ACC_W +: ACC_W] <= w_acc_i[k];
        r_out_q[k*ACC_W +: ACC_W] <= w_acc_q[k];
      end
      if (r_out_valid && !bus.out_ready) begin
        r_overrun <= 1'b1;
      end
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_i     = r_out_i;
  assign bus.out_q     = r_out_q;
  assign bus.out_count = r_out_count;
  assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_epl_integrate_dump.sv
// Directed bench for epl_integrate_dump: a default-width instance and an
// ACC_W=8 instance for the accumulator overflow case.
module tb_epl_integrate_dump;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 CLK = ~CLK;

  epl_integrate_dump_if bus ();
  epl_integrate_dump_if #(.ACC_W(8)) bus8 ();

  epl_integrate_dump u_dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  epl_integrate_dump #(.ACC_W(8)) u_dut8 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus8)
  );

  function automatic logic signed [31:0] tap_i(input int k);
    return bus.out_i[k*32 +: 32];
  endfunction

  function automatic logic signed [31:0] tap_q(input int k);
    return bus.out_q[k*32 +: 32];
  endfunction

  function automatic logic signed [7:0] tap8(input int k);
    return bus8.out_i[k*8 +: 8];
  endfunction

  task automatic drv(input logic v, input logic signed [2:0] s, input logic signed [3:0] li,
                     input logic signed [3:0] lq, input logic p, input logic e);
    bus.sample_valid = v;
    bus.sample_in    = s;
    bus.lo_i         = li;
    bus.lo_q         = lq;
    bus.prn_chip     = p;
    bus.epoch        = e;
    @(posedge CLK);
    #1;
  endtask

  task automatic drv8(input logic v, input logic signed [2:0] s, input logic signed [3:0] li,
                      input logic p, input logic e);
    bus8.sample_valid = v;
    bus8.sample_in    = s;
    bus8.lo_i         = li;
    bus8.lo_q         = 4'sd0;
    bus8.prn_chip     = p;
    bus8.epoch        = e;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    drv(1'b0, 3'sd0, 4'sd0, 4'sd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    bus.sample_valid  = 1'b0;
    bus.epoch         = 1'b0;
    bus8.sample_valid = 1'b0;
    bus8.epoch        = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    n_tests++; if (bus.out_i !== '0) begin n_fail++; $display("FAIL reset_out_i: got %h want 0", bus.out_i); end
    n_tests++; if (bus.out_q !== '0) begin n_fail++; $display("FAIL reset_out_q: got %h want 0", bus.out_q); end
    n_tests++; if (bus.out_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.out_count); end
    n_tests++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", bus.overrun); end
    n_tests++; if (bus8.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid8: got %b want 0", bus8.out_valid); end
  endtask

  task automatic test_basic();
    do_reset();
    bus.out_ready = 1'b1;
    repeat (4) drv(1'b1, 3'sd0, 4'sd0, 4'sd0, 1'b1, 1'b0);
    drv(1'b1, 3'sd3, 4'sd1, 4'sd0, 1'b1, 1'b1);
    repeat (9) drv(1'b1, 3'sd3, 4'sd1, 4'sd0, 1'b1, 1'b0);
    drv(1'b1, 3'sd3, 4'sd1, 4'sd0, 1'b1, 1'b1);
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_latency1: got %b want 0", bus.out_valid); end
    idle();
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency2: got %b want 1", bus.out_valid); end
    for (int k = 0; k < 3; k++) begin
      n_tests++; if (tap_i(k) !== 32'sd30) begin n_fail++; $display("FAIL basic_i%0d: got %0d want 30", k, tap_i(k)); end
      n_tests++; if (tap_q(k) !== 32'sd0) begin n_fail++; $display("FAIL basic_q%0d: got %0d want 0", k, tap_q(k)); end
    end
    n_tests++; if (bus.out_count !== 16'd10) begin n_fail++; $display("FAIL basic_count: got %0d want 10", bus.out_count); end
    idle();
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_accept: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_arm_only();
    do_reset();
    bus.out_ready = 1'b1;
    drv(1'b1, 3'sd1, 4'sd1, 4'sd0, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      idle();
      n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL arm_no_dump%0d: got %b want 0", c, bus.out_valid); end
    end
    repeat (4) drv(1'b1, 3'sd1, 4'sd1, 4'sd0, 1'b1, 1'b0);
    drv(1'b1, 3'sd1, 4'sd1, 4'sd0, 1'b1, 1'b1);
    idle();
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL arm_dump_valid: got %b want 1", bus.out_valid); end
    n_tests++; if (bus.out_count !== 16'd5) begin n_fail++; $display("FAIL arm_count: got %0d want 5", bus.out_count); end
    n_tests++; if (tap_i(0) !== 32'sd5) begin n_fail++; $display("FAIL arm_i0: got %0d want 5", tap_i(0)); end
  endtask

  task automatic test_epl();
    logic [3:0]       pat;
    logic             prevc;
    logic             p;
    logic signed [2:0] s;
    pat   = 4'b0011;
    prevc = 1'b0;
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i <= 12; i++) begin
      p = pat[i % 4];
      s = prevc ? 3'sd1 : -3'sd1;
      drv(1'b1, s, 4'sd1, 4'sd0, p, (i == 4) || (i == 12));
      prevc = p;
    end
    idle();
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL epl_valid: got %b want 1", bus.out_valid); end
    n_tests++; if (tap_i(0) !== 32'sd0) begin n_fail++; $display("FAIL epl_early: got %0d want 0", tap_i(0)); end
    n_tests++; if (tap_i(1) !== 32'sd8) begin n_fail++; $display("FAIL epl_prompt: got %0d want 8", tap_i(1)); end
    n_tests++; if (tap_i(2) !== 32'sd0) begin n_fail++; $display("FAIL epl_late: got %0d want 0", tap_i(2)); end
    n_tests++; if (bus.out_count !== 16'd8) begin n_fail++; $display("FAIL epl_count: got %0d want 8", bus.out_count); end
  endtask

  task automatic test_overrun();
    do_reset();
    bus.out_ready = 1'b0;
    repeat (2) drv(1'b1, 3'sd1, 4'sd1, -4'sd1, 1'b1, 1'b0);
    drv(1'b1, 3'sd1, 4'sd1, -4'sd1, 1'b1, 1'b1);
    repeat (9) drv(1'b1, 3'sd1, 4'sd1, -4'sd1, 1'b1, 1'b0);
    drv(1'b1, 3'sd1, 4'sd1, -4'sd1, 1'b1, 1'b1);
    repeat (11) drv(1'b1, 3'sd1, 4'sd1, -4'sd1, 1'b1, 1'b0);
    n_tests++; if (bus.out_count !== 16'd10) begin n_fail++; $display("FAIL ovr_first_count: got %0d want 10", bus.out_count); end
    n_tests++; if (tap_q(1) !== -32'sd10) begin n_fail++; $display("FAIL ovr_first_q: got %0d want -10", tap_q(1)); end
    n_tests++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_early: got %b want 0", bus.overrun); end
    drv(1'b1, 3'sd1, 4'sd1, -4'sd1, 1'b1, 1'b1);
    idle();
    n_tests++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b want 1", bus.overrun); end
    n_tests++; if (bus.out_count !== 16'd12) begin n_fail++; $display("FAIL ovr_count: got %0d want 12", bus.out_count); end
    n_tests++; if (tap_i(1) !== 32'sd12) begin n_fail++; $display("FAIL ovr_i: got %0d want 12", tap_i(1)); end
    idle();
    n_tests++; if (bus.out_valid !== 1'b1 || bus.out_count !== 16'd12) begin n_fail++; $display("FAIL ovr_hold: got valid=%b count=%0d want 1/12", bus.out_valid, bus.out_count); end
    bus.out_ready = 1'b1;
    idle();
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_accept: got %b want 0", bus.out_valid); end
    n_tests++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b want 1", bus.overrun); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.out_ready = 1'b1;
    repeat (2) drv(1'b1, 3'sd0, 4'sd1, 4'sd0, 1'b1, 1'b0);
    drv(1'b1, 3'sd1, 4'sd1, 4'sd0, 1'b1, 1'b1);
    drv(1'b1, 3'sd2, 4'sd1, 4'sd0, 1'b1, 1'b1);
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_arm: got %b want 0", bus.out_valid); end
    drv(1'b1, 3'sd3, 4'sd1, 4'sd0, 1'b1, 1'b1);
    n_tests++; if (bus.out_valid !== 1'b1 || tap_i(1) !== 32'sd1) begin n_fail++; $display("FAIL b2b_first: got valid=%b i=%0d want 1/1", bus.out_valid, tap_i(1)); end
    idle();
    n_tests++; if (bus.out_valid !== 1'b1 || tap_i(1) !== 32'sd2) begin n_fail++; $display("FAIL b2b_second: got valid=%b i=%0d want 1/2", bus.out_valid, tap_i(1)); end
    n_tests++; if (bus.overrun !== 1'b0 || bus.out_count !== 16'd1) begin n_fail++; $display("FAIL b2b_ovr_count: got ovr=%b count=%0d want 0/1", bus.overrun, bus.out_count); end
    idle();
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drop: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_acc_limit();
    logic signed [7:0] exp8;
`ifdef EPL_ACC_SAT_EN
    exp8 = 8'sd127;
`else
    exp8 = -8'sd46;
`endif
    do_reset();
    bus8.out_ready = 1'b1;
    repeat (2) drv8(1'b1, 3'sd3, 4'sd7, 1'b1, 1'b0);
    drv8(1'b1, 3'sd3, 4'sd7, 1'b1, 1'b1);
    repeat (9) drv8(1'b1, 3'sd3, 4'sd7, 1'b1, 1'b0);
    drv8(1'b1, 3'sd3, 4'sd7, 1'b1, 1'b1);
    drv8(1'b0, 3'sd0, 4'sd0, 1'b0, 1'b0);
    n_tests++; if (bus8.out_valid !== 1'b1) begin n_fail++; $display("FAIL acc8_valid: got %b want 1", bus8.out_valid); end
    for (int k = 0; k < 3; k++) begin
      n_tests++; if (tap8(k) !== exp8) begin n_fail++; $display("FAIL acc8_i%0d: got %0d want %0d", k, tap8(k), exp8); end
    end
    n_tests++; if (bus8.out_count !== 16'd10) begin n_fail++; $display("FAIL acc8_count: got %0d want 10", bus8.out_count); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    bus.out_ready = 1'b0;
    drv(1'b1, 3'sd2, 4'sd1, 4'sd1, 1'b1, 1'b1);
    repeat (2) drv(1'b1, 3'sd2, 4'sd1, 4'sd1, 1'b1, 1'b0);
    drv(1'b1, 3'sd2, 4'sd1, 4'sd1, 1'b1, 1'b1);
    idle();
    n_tests++; if (bus.out_valid !== 1'b1 || bus.out_count !== 16'd3) begin n_fail++; $display("FAIL mid_pre: got valid=%b count=%0d want 1/3", bus.out_valid, bus.out_count); end
    repeat (2) drv(1'b1, 3'sd2, 4'sd1, 4'sd1, 1'b1, 1'b0);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    n_tests++; if (bus.out_valid !== 1'b0 || bus.out_count !== 16'd0 || bus.overrun !== 1'b0) begin n_fail++; $display("FAIL mid_ctrl: got valid=%b count=%0d ovr=%b want 0/0/0", bus.out_valid, bus.out_count, bus.overrun); end
    n_tests++; if (bus.out_i !== '0 || bus.out_q !== '0) begin n_fail++; $display("FAIL mid_data: got i=%h q=%h want 0", bus.out_i, bus.out_q); end
    drv(1'b1, 3'sd2, 4'sd1, 4'sd1, 1'b1, 1'b1);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    drv(1'b1, 3'sd1, 4'sd1, 4'sd0, 1'b1, 1'b1);
    repeat (3) drv(1'b1, 3'sd1, 4'sd1, 4'sd0, 1'b1, 1'b0);
    repeat (3) idle();
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_arm_only: got %b want 0", bus.out_valid); end
    drv(1'b1, 3'sd1, 4'sd1, 4'sd0, 1'b1, 1'b1);
    idle();
    n_tests++; if (bus.out_valid !== 1'b1 || bus.out_count !== 16'd4) begin n_fail++; $display("FAIL mid_after: got valid=%b count=%0d want 1/4", bus.out_valid, bus.out_count); end
  endtask

  initial begin
    bus.sample_valid  = 1'b0;
    bus.sample_in     = 3'sd0;
    bus.lo_i          = 4'sd0;
    bus.lo_q          = 4'sd0;
    bus.prn_chip      = 1'b0;
    bus.epoch         = 1'b0;
    bus.out_ready     = 1'b1;
    bus8.sample_valid = 1'b0;
    bus8.sample_in    = 3'sd0;
    bus8.lo_i         = 4'sd0;
    bus8.lo_q         = 4'sd0;
    bus8.prn_chip     = 1'b0;
    bus8.epoch        = 1'b0;
    bus8.out_ready    = 1'b1;
    test_reset();
    test_basic();
    test_arm_only();
    test_epl();
    test_overrun();
    test_back_to_back();
    test_acc_limit();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
